// File: rtl/pwp_pkg.sv
// Shared types and elaboration helpers for the pixel window packer.
package pwp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } state_e;

    localparam int DEF_BITS_PER_PIXEL = 2;
    localparam int DEF_WORD_WIDTH     = 32;
    localparam int PPW                = DEF_WORD_WIDTH / DEF_BITS_PER_PIXEL;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    // Whole words per window row and a power-of-2 FIFO keep the packer and pointers simple.
    function automatic bit params_legal(input int bpp, input int ww, input int win_w, input int depth);
        return (bpp > 0) && (ww >= bpp) && ((ww % bpp) == 0) &&
               (((win_w * bpp) % ww) == 0) && (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/pixel_window_packer_sync_fifo.sv
// Synchronous FIFO; the head entry is read straight from the storage registers.
module sync_fifo
    import pwp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic             i_Wr_En,
    input  logic [WIDTH-1:0] i_Wr_Data,
    input  logic             i_Rd_En,
    output logic [WIDTH-1:0] o_Rd_Data,
    output logic             o_Full,
    output logic             o_Empty
);
    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_ok;
    logic             rd_ok;

    // A read in the same cycle frees the slot, so a full FIFO still takes the write.
    assign rd_ok     = i_Rd_En && !o_Empty;
    assign wr_ok     = i_Wr_En && (!o_Full || rd_ok);
    assign o_Full    = (count == (AW+1)'(DEPTH));
    assign o_Empty   = (count == '0);
    assign o_Rd_Data = mem[rd_ptr];

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= i_Wr_Data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_window_packer.sv
// Captures one frame's in-window pixels, packs them MSB-first into words and streams them out.
module pixel_window_packer
    import pwp_pkg::*;
#(
    parameter int BITS_PER_PIXEL = DEF_BITS_PER_PIXEL,
    parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
    parameter int COORD_WIDTH    = 10,
    parameter int WIN_X0         = 16,
    parameter int WIN_W          = 256,
    parameter int WIN_Y0         = 0,
    parameter int WIN_H          = 256,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst_L,
    input  logic                      i_Arm,
    input  logic [COORD_WIDTH-1:0]    i_Row,
    input  logic [COORD_WIDTH-1:0]    i_Column,
    input  logic [BITS_PER_PIXEL-1:0] i_Pixel,
    output logic [WORD_WIDTH-1:0]     o_Word,
    output logic                      o_Word_Valid,
    input  logic                      i_Word_Ready,
    output logic                      o_Busy,
    output logic                      o_Done,
    output logic                      o_Overflow,
    output logic [15:0]               o_Word_Count,
    output state_e                    o_State
);
    localparam int PIX_PER_WORD = WORD_WIDTH / BITS_PER_PIXEL;
    localparam int CNT_W        = (clog2(PIX_PER_WORD) > 0) ? clog2(PIX_PER_WORD) : 1;
    localparam logic [CNT_W-1:0]     PIX_LAST = CNT_W'(PIX_PER_WORD - 1);
    localparam logic [COORD_WIDTH:0] X_LO     = (COORD_WIDTH+1)'(WIN_X0);
    localparam logic [COORD_WIDTH:0] X_HI     = (COORD_WIDTH+1)'(WIN_X0 + WIN_W);
    localparam logic [COORD_WIDTH:0] X_LAST   = (COORD_WIDTH+1)'(WIN_X0 + WIN_W - 1);
    localparam logic [COORD_WIDTH:0] Y_LO     = (COORD_WIDTH+1)'(WIN_Y0);
    localparam logic [COORD_WIDTH:0] Y_HI     = (COORD_WIDTH+1)'(WIN_Y0 + WIN_H);
    localparam logic [COORD_WIDTH:0] Y_LAST   = (COORD_WIDTH+1)'(WIN_Y0 + WIN_H - 1);

    if (!params_legal(BITS_PER_PIXEL, WORD_WIDTH, WIN_W, FIFO_DEPTH)) begin : g_bad_params
        $error("pixel_window_packer: illegal parameter combination");
    end

    state_e                 state;
    logic [WORD_WIDTH-1:0]  shift_reg;
    logic [WORD_WIDTH-1:0]  next_shift;
    logic [CNT_W-1:0]       pix_cnt;
    logic [COORD_WIDTH:0]   row_x;
    logic [COORD_WIDTH:0]   col_x;
    logic                   in_win;
    logic                   frame_start;
    logic                   last_pixel;
    logic                   sample;
    logic                   push;
    logic                   pop;
    logic                   drop;
    logic                   fifo_full;
    logic                   fifo_empty;

    // Coordinates are widened by one bit so the window end sums cannot wrap.
    assign row_x       = {1'b0, i_Row};
    assign col_x       = {1'b0, i_Column};
    assign in_win      = (row_x >= Y_LO) && (row_x < Y_HI) && (col_x >= X_LO) && (col_x < X_HI);
    assign frame_start = (i_Row == '0) && (i_Column == '0);
    assign last_pixel  = (row_x == Y_LAST) && (col_x == X_LAST);
    assign sample      = in_win && (((state == ARMED) && frame_start) ||
                                    ((state == CAPTURE) && !frame_start));

    // The pushed word already contains the current pixel in its LSBs.
    if (PIX_PER_WORD == 1) begin : g_one_pix
        assign next_shift = i_Pixel;
    end else begin : g_multi_pix
        assign next_shift = {shift_reg[WORD_WIDTH-BITS_PER_PIXEL-1:0], i_Pixel};
    end

    assign push         = sample && (pix_cnt == PIX_LAST);
    assign pop          = o_Word_Valid && i_Word_Ready;
    assign drop         = push && fifo_full && !pop;
    assign o_Word_Valid = !fifo_empty;
    assign o_Busy       = (state != IDLE);
    assign o_State      = state;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state        <= IDLE;
            shift_reg    <= '0;
            pix_cnt      <= '0;
            o_Done       <= 1'b0;
            o_Overflow   <= 1'b0;
            o_Word_Count <= '0;
        end else begin
            o_Done <= 1'b0;
            if (sample) begin
                shift_reg <= next_shift;
                pix_cnt   <= push ? '0 : pix_cnt + CNT_W'(1);
            end
            if (push && (o_Word_Count != 16'hFFFF)) o_Word_Count <= o_Word_Count + 16'd1;
            if (drop) o_Overflow <= 1'b1;
            case (state)
                IDLE: begin
                    if (i_Arm) begin
                        state        <= ARMED;
                        o_Overflow   <= 1'b0;
                        o_Word_Count <= '0;
                        shift_reg    <= '0;
                        pix_cnt      <= '0;
                    end
                end
                ARMED: begin
                    if (frame_start) begin
                        if (sample && last_pixel) begin
                            state  <= IDLE;
                            o_Done <= 1'b1;
                        end else begin
                            state <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    // A new frame before the window finished means the capture is incomplete.
                    if (frame_start) begin
                        state      <= IDLE;
                        o_Overflow <= 1'b1;
                        shift_reg  <= '0;
                        pix_cnt    <= '0;
                    end else if (sample && last_pixel) begin
                        state  <= IDLE;
                        o_Done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clk     (i_Clk),
        .i_Rst_L   (i_Rst_L),
        .i_Wr_En   (push),
        .i_Wr_Data (next_shift),
        .i_Rd_En   (pop),
        .o_Rd_Data (o_Word),
        .o_Full    (fifo_full),
        .o_Empty   (fifo_empty)
    );

endmodule

// File: tb/tb_pixel_window_packer.sv
// Bench for pixel_window_packer: reduced-window instance checked every cycle against a
// queue-based frame model, plus a 4-bit-pixel instance with literal expectations.
module tb_pixel_window_packer;
    import pwp_pkg::*;

    localparam int BPP   = 2;
    localparam int WW    = 32;
    localparam int CW    = 10;
    localparam int X0    = 16;
    localparam int WIN_W = 32;
    localparam int Y0    = 2;
    localparam int WIN_H = 4;
    localparam int DEPTH = 4;
    localparam int PPW_A = WW / BPP;
    localparam int ROWS  = Y0 + WIN_H + 2;
    localparam int COLS  = X0 + WIN_W + 4;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_l, arm, ready;
    logic [CW-1:0]  row, col;
    logic [BPP-1:0] pix;
    logic [WW-1:0]  o_word;
    logic           o_valid, o_busy, o_done, o_ovf;
    logic [15:0]    o_cnt;
    state_e         o_state;

    logic           arm_b, ready_b;
    logic [CW-1:0]  row_b, col_b;
    logic [3:0]     pix_b;
    logic [15:0]    word_b;
    logic           valid_b, busy_b, done_b, ovf_b;
    logic [15:0]    cnt_b;
    state_e         state_b;

    pixel_window_packer #(
        .BITS_PER_PIXEL(BPP), .WORD_WIDTH(WW), .COORD_WIDTH(CW), .WIN_X0(X0), .WIN_W(WIN_W),
        .WIN_Y0(Y0), .WIN_H(WIN_H), .FIFO_DEPTH(DEPTH)
    ) u_dut (
        .i_Clk(clk), .i_Rst_L(rst_l), .i_Arm(arm), .i_Row(row), .i_Column(col), .i_Pixel(pix),
        .o_Word(o_word), .o_Word_Valid(o_valid), .i_Word_Ready(ready), .o_Busy(o_busy),
        .o_Done(o_done), .o_Overflow(o_ovf), .o_Word_Count(o_cnt), .o_State(o_state)
    );

    pixel_window_packer #(
        .BITS_PER_PIXEL(4), .WORD_WIDTH(16), .COORD_WIDTH(CW), .WIN_X0(0), .WIN_W(8),
        .WIN_Y0(0), .WIN_H(2), .FIFO_DEPTH(16)
    ) u_dut_b (
        .i_Clk(clk), .i_Rst_L(rst_l), .i_Arm(arm_b), .i_Row(row_b), .i_Column(col_b), .i_Pixel(pix_b),
        .o_Word(word_b), .o_Word_Valid(valid_b), .i_Word_Ready(ready_b), .o_Busy(busy_b),
        .o_Done(done_b), .o_Overflow(ovf_b), .o_Word_Count(cnt_b), .o_State(state_b)
    );

    // scoreboard state
    int  n_checks = 0;
    int  n_fail   = 0;
    bit  cmp_en   = 1'b0;
    int  mode     = 0;
    int  m_cnt    = 0;
    bit  m_ovf    = 1'b0;
    bit  m_done   = 1'b0;
    int  done_seen   = 0;
    int  done_b_seen = 0;
    logic [BPP-1:0] pix_q[$];
    logic [WW-1:0]  exp_q[$];
    logic [WW-1:0]  popped[$];
    logic [WW-1:0]  frame_words[$];
    logic [15:0]    popped_b[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WW-1:0] q_at(input int idx);
        return (idx < popped.size()) ? popped[idx] : 'x;
    endfunction

    // Frame model: collect in-window pixels of the captured frame, pack every PPW of them,
    // and keep the output FIFO as a bounded queue.
    function automatic void model_step();
        int r, c;
        bit in_win, fs, take, pop;
        logic [WW-1:0] w;
        r = int'(row);
        c = int'(col);
        in_win = (r >= Y0) && (r < Y0 + WIN_H) && (c >= X0) && (c < X0 + WIN_W);
        fs     = (r == 0) && (c == 0);
        take   = in_win && (((mode == 1) && fs) || ((mode == 2) && !fs));
        pop    = (exp_q.size() > 0) && ready;
        m_done = 1'b0;
        case (mode)
            0: if (arm) begin mode = 1; m_ovf = 1'b0; m_cnt = 0; pix_q.delete(); end
            1: if (fs) mode = 2;
            2: if (fs) begin mode = 0; m_ovf = 1'b1; pix_q.delete(); end
            default: mode = 0;
        endcase
        if (pop) void'(exp_q.pop_front());
        if (take) begin
            pix_q.push_back(pix);
            if (pix_q.size() == PPW_A) begin
                w = '0;
                foreach (pix_q[i]) w = (w << BPP) | WW'(pix_q[i]);
                pix_q.delete();
                if (m_cnt < 65535) m_cnt++;
                if (exp_q.size() < DEPTH) exp_q.push_back(w);
                else m_ovf = 1'b1;
            end
            if ((r == Y0 + WIN_H - 1) && (c == X0 + WIN_W - 1)) begin
                mode   = 0;
                m_done = 1'b1;
            end
        end
    endfunction

    always @(posedge clk) begin
        if (o_valid && ready) popped.push_back(o_word);
        if (valid_b && ready_b) popped_b.push_back(word_b);
        if (done_b) done_b_seen++;
        if (!rst_l) begin
            mode = 0; m_cnt = 0; m_ovf = 1'b0; m_done = 1'b0;
            pix_q.delete();
            exp_q.delete();
        end else begin
            model_step();
        end
    end

    // compare process
    always @(negedge clk) begin
        if (cmp_en) begin
            check("valid", o_valid, exp_q.size() > 0);
            if (exp_q.size() > 0) check("word", o_word, exp_q[0]);
            check("busy", o_busy, mode != 0);
            check("done", o_done, m_done);
            check("overflow", o_ovf, m_ovf);
            check("word_count", o_cnt, m_cnt);
            check("state", o_state, (mode == 0) ? IDLE : (mode == 1) ? ARMED : CAPTURE);
            if (o_done) done_seen++;
        end
    end

    // driver tasks
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rst_l = 1'b1; arm = 1'b0; row = CW'(ROWS); col = '0; pix = '0;
        end
    endtask

    task automatic arm_pulse();
        @(negedge clk);
        arm = 1'b1; row = CW'(ROWS); col = '0;
        @(negedge clk);
        arm = 1'b0;
    endtask

    // pat: 0 = column[1:0], 1 = 3 at the first window column, else random.
    // rpol: 0 ready high, 1 ready low, 2 random, 3 low until the 5th word completes.
    task automatic drive_frame(input int pat, input int rpol, input int trunc_row, input int rst_row);
        int n_pix;
        bit in_win;
        logic [WW-1:0] acc;
        n_pix = 0;
        acc = '0;
        frame_words.delete();
        for (int r = 0; r < ROWS; r++) begin
            if (r == trunc_row) return;
            for (int c = 0; c < COLS; c++) begin
                @(negedge clk);
                row = CW'(r); col = CW'(c); arm = 1'b0;
                rst_l = !((r == rst_row) && ((c == 20) || (c == 21)));
                case (pat)
                    0:       pix = BPP'(c);
                    1:       pix = (c == X0) ? 2'b11 : 2'b00;
                    default: pix = BPP'($urandom);
                endcase
                in_win = (r >= Y0) && (r < Y0 + WIN_H) && (c >= X0) && (c < X0 + WIN_W);
                if (in_win) begin
                    n_pix++;
                    acc = (acc << BPP) | WW'(pix);
                    if ((n_pix % PPW_A) == 0) frame_words.push_back(acc);
                end
                case (rpol)
                    0: ready = 1'b1;
                    1: ready = 1'b0;
                    2: begin
                        ready = ($urandom_range(0, 3) != 0);
                        arm   = (r < Y0 + WIN_H - 1) && ($urandom_range(0, 40) == 0);
                    end
                    3: ready = (n_pix >= 5 * PPW_A);
                    default: ready = 1'b1;
                endcase
            end
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                row = CW'(r); col = CW'(COLS + 5); pix = BPP'($urandom); arm = 1'b0; rst_l = 1'b1;
            end
        end
    endtask

    task automatic drain(input int budget);
        int i;
        i = 0;
        ready = 1'b1;
        while (o_valid && (i < budget)) begin
            @(negedge clk);
            ready = 1'b1;
            i++;
        end
        check("drain_timeout", o_valid, 1'b0);
    endtask

    initial begin
        rst_l = 1'b0; arm = 1'b0; ready = 1'b0; row = CW'(ROWS); col = '0; pix = '0;
        arm_b = 1'b0; ready_b = 1'b1; row_b = CW'(5); col_b = '0; pix_b = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", o_valid, 1'b0);
        check("rst_word", o_word, '0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_done", o_done, 1'b0);
        check("rst_overflow", o_ovf, 1'b0);
        check("rst_count", o_cnt, 16'd0);
        check("rst_state", o_state, IDLE);
        check("rst_b_valid", valid_b, 1'b0);
        rst_l = 1'b1;
        cmp_en = 1'b1;

        // column-pattern frame, ready always high
        popped.delete(); done_seen = 0;
        arm_pulse(); drive_frame(0, 0, -1, -1); idle(4);
        check("t1_first_word", q_at(0), 32'h1B1B1B1B);
        check("t1_num_words", popped.size(), 8);
        check("t1_done_once", done_seen, 1);
        check("t1_count", o_cnt, 16'd8);
        check("t1_overflow", o_ovf, 1'b0);

        // single marked pixel per row at the window's first column
        popped.delete();
        arm_pulse(); drive_frame(1, 0, -1, -1); idle(4);
        check("t2_word0", q_at(0), 32'hC0000000);
        check("t2_word1", q_at(1), 32'h00000000);
        check("t2_word2", q_at(2), 32'hC0000000);

        // consumer stalled for the whole frame
        done_seen = 0;
        arm_pulse(); drive_frame(2, 1, -1, -1); idle(2);
        check("t3_overflow", o_ovf, 1'b1);
        check("t3_count", o_cnt, 16'd8);
        check("t3_done", done_seen, 1);
        popped.delete(); drain(20);
        check("t3_held", popped.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++) check("t3_held_word", q_at(i), frame_words[i]);

        // release at full exactly when a word is pushed
        popped.delete();
        arm_pulse(); drive_frame(2, 3, -1, -1); idle(2); drain(20);
        check("t4_overflow", o_ovf, 1'b0);
        check("t4_num_words", popped.size(), 8);
        for (int i = 0; i < 8; i++) check("t4_order", q_at(i), frame_words[i]);

        // random backpressure and stray arm pulses
        for (int k = 0; k < 2; k++) begin
            done_seen = 0;
            arm_pulse(); drive_frame(2, 2, -1, -1); idle(2); drain(20);
            check("t5_done", done_seen, 1);
        end

        // reset in the middle of capture, then a clean capture
        arm_pulse(); drive_frame(0, 0, -1, 4); idle(2);
        check("t6_count_cleared", o_cnt, 16'd0);
        check("t6_fifo_empty", o_valid, 1'b0);
        check("t6_idle", o_busy, 1'b0);
        popped.delete(); done_seen = 0;
        arm_pulse(); drive_frame(0, 0, -1, -1); idle(4);
        check("t6_num_words", popped.size(), 8);
        check("t6_first_word", q_at(0), 32'h1B1B1B1B);
        check("t6_count", o_cnt, 16'd8);
        check("t6_done", done_seen, 1);

        // truncated frame
        done_seen = 0;
        arm_pulse(); drive_frame(0, 0, 4, -1);
        @(negedge clk);
        row = '0; col = '0;
        idle(3);
        check("t7_overflow", o_ovf, 1'b1);
        check("t7_no_done", done_seen, 0);
        check("t7_idle", o_busy, 1'b0);
        check("t7_count", o_cnt, 16'd4);

        // 4-bit pixels into 16-bit words, 8x2 window
        popped_b.delete(); done_b_seen = 0;
        @(negedge clk); arm_b = 1'b1;
        @(negedge clk); arm_b = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                row_b = CW'(r); col_b = CW'(c); pix_b = 4'(c);
            end
        end
        @(negedge clk);
        row_b = CW'(5); col_b = '0;
        repeat (4) @(negedge clk);
        check("b_num_words", popped_b.size(), 4);
        for (int i = 0; i < 4; i++)
            check("b_word", (i < popped_b.size()) ? popped_b[i] : 16'hxxxx,
                  ((i % 2) == 0) ? 16'h0123 : 16'h4567);
        check("b_done", done_b_seen, 1);
        check("b_count", cnt_b, 16'd4);
        check("b_overflow", ovf_b, 1'b0);
        check("b_idle", busy_b, 1'b0);

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
